// File: rtl/instruction_fetch.sv
// instruction_fetch
//    Fetch stage between the program counter and the decoder. Issues one
//    outstanding read at a time to instruction memory (req held until ack),
//    tags each returned word with its address and queues it in a small
//    prefetch FIFO read by the decoder over valid/ready.
//
// Ports
//    clock, reset_n            rising-edge clock, synchronous active-low reset
//    enable                    permits new fetches
//    pc_in / pc_step           current PC in; one-cycle strobe when it is consumed
//    flush                     drop all buffered and in-flight words
//    mem_req/mem_addr          read request, held with a stable address until ack
//    mem_ack/mem_rdata         read completion and data
//    instr_valid/instr_ready   decoder handshake on the FIFO head
//    instr_data/instr_pc       head word and its address
//    fetch_err                 sticky memory-timeout flag
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no read outstanding; issue when enabled and FIFO has room
// ST_BUSY  | read outstanding, waiting for mem_ack (with timeout)
// ST_ERR   | memory timed out; no more fetches until reset, FIFO drains

module instruction_fetch #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 2,
   parameter int MAX_WAIT   = 15
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic [ADDR_WIDTH-1:0] pc_in,
   output logic                  pc_step,
   input  logic                  flush,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr_data,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  fetch_err
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
   localparam logic [7:0]    MAX_WAIT_C = 8'(MAX_WAIT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  mem_req_q, mem_req_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  pc_step_q, pc_step_d;
   logic                  fetch_err_q, fetch_err_d;
   logic                  discard_q, discard_d;
   logic [7:0]            wait_q, wait_d;
   logic [CW-1:0]         count_q, count_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_pc_d   [FIFO_DEPTH];
   logic                  push;
   logic                  pop;

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      pc_step_d   = 1'b0;
      fetch_err_d = fetch_err_q;
      discard_d   = discard_q;
      wait_d      = wait_q;
      count_d     = count_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fifo_data_d = fifo_data_q;
      fifo_pc_d   = fifo_pc_q;
      push        = 1'b0;
      pop         = (count_q != '0) && instr_ready && !flush;

      unique case (state_q)
         ST_IDLE: begin
            // count uses the pre-edge value, so a full FIFO being popped
            // this edge still blocks issue; keeps "room on ack" guaranteed.
            if (enable && !flush && (count_q < DEPTH_C)) begin
               state_d    = ST_BUSY;
               mem_req_d  = 1'b1;
               mem_addr_d = pc_in;
               pc_step_d  = 1'b1;
               wait_d     = '0;
            end
         end
         ST_BUSY: begin
            if (mem_ack) begin
               push      = !discard_q && !flush;
               discard_d = 1'b0;
               mem_req_d = 1'b0;
               state_d   = ST_IDLE;
            end else begin
               // A redirect mid-read lets the read finish, then drops it.
               if (flush) begin
                  discard_d = 1'b1;
               end
               wait_d = wait_q + 8'd1;
               if (wait_d == MAX_WAIT_C) begin
                  mem_req_d   = 1'b0;
                  fetch_err_d = 1'b1;
                  state_d     = ST_ERR;
               end
            end
         end
         ST_ERR: begin
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      if (flush) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) begin
            fifo_data_d[wr_ptr_q] = mem_rdata;
            fifo_pc_d[wr_ptr_q]   = mem_addr_q;
            wr_ptr_d              = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_d = count_q + 1'b1;
         end else if (pop && !push) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         pc_step_q   <= 1'b0;
         fetch_err_q <= 1'b0;
         discard_q   <= 1'b0;
         wait_q      <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_q[i] <= '0;
            fifo_pc_q[i]   <= '0;
         end
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         pc_step_q   <= pc_step_d;
         fetch_err_q <= fetch_err_d;
         discard_q   <= discard_d;
         wait_q      <= wait_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_data_q <= fifo_data_d;
         fifo_pc_q   <= fifo_pc_d;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign pc_step     = pc_step_q;
   assign fetch_err   = fetch_err_q;
   assign instr_valid = (count_q != '0);
   assign instr_data  = fifo_data_q[rd_ptr_q];
   assign instr_pc    = fifo_pc_q[rd_ptr_q];

endmodule
